// File: rtl/ddr_sched_pkg.sv
// DDR frame scheduler shared types and codes.
// Imported by the scheduler top and its sync sub-block.
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    WR_CMD,
    WR_DATA,
    RD_CMD,
    RD_WAIT
  } state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam logic GNT_WR = 1'b0;
  localparam logic GNT_RD = 1'b1;

endpackage

// File: rtl/ddr_frame_scheduler_sync.sv
// Frame-start event synchroniser: 2-FF sync of an
// asynchronous level followed by a rising-edge pulse.
module load_event_sync
  import ddr_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  logic [2:0] sync_q;

  // two sync stages plus one history stage for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], async_i};
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ddr_frame_scheduler.sv
// Burst scheduler between ISP write FIFO, HDMI read FIFO
// and the DDR3 app port, with ping-pong frame banks.
module ddr_frame_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int unsigned ADDR_W    = 29,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned BURST_LEN = 240,
  parameter int unsigned ADDR_STEP = 1920,
  parameter int unsigned FRAME_MAX = 2073600,
  parameter int unsigned BANK_OFS  = 32'h0040_0000,
  parameter int unsigned RD_THRESH = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              calib_done,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [CNT_W-1:0]  wrfifo_level,
  input  logic [CNT_W-1:0]  rdfifo_level,
  output logic              wrfifo_rden,
  output logic              rdfifo_wren,
  output logic              rdfifo_clr,
  output logic [2:0]        app_cmd,
  output logic              app_cmd_en,
  output logic [ADDR_W-1:0] app_addr,
  output logic [5:0]        app_burst_number,
  input  logic              app_cmd_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  output logic              busy
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  WR_MIN = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  RD_MAX = CNT_W'(RD_THRESH);
  localparam logic [ADDR_W-1:0] OFS1   = ADDR_W'(BANK_OFS);
  localparam logic [ADDR_W:0]   STEP_X = (ADDR_W+1)'(ADDR_STEP);
  localparam logic [ADDR_W:0]   FMAX_X = (ADDR_W+1)'(FRAME_MAX);
  localparam logic [5:0]        BNUM   = 6'(BURST_LEN - 1);

  state_e              state_q, state_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic                rd_src_q, rd_src_d;
  logic                frame_ok_q, frame_ok_d;
  logic                rr_last_q, rr_last_d;
  logic                wr_pend_q, wr_pend_d;
  logic                rd_pend_q, rd_pend_d;
  logic                clr_q, clr_d;
  logic [ADDR_W-1:0]   wr_off_q, wr_off_d;
  logic [ADDR_W-1:0]   rd_off_q, rd_off_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                wr_evt, rd_evt;
  logic                wr_el, rd_el;

  function automatic logic [ADDR_W-1:0] next_off(
    input logic [ADDR_W-1:0] off
  );
    logic [ADDR_W:0] sum;
    sum = {1'b0, off} + STEP_X;
    if (sum >= FMAX_X) next_off = '0;
    else               next_off = sum[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] base(input logic b);
    base = b ? OFS1 : '0;
  endfunction

  load_event_sync u_wr_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (wr_load),
    .pulse_o (wr_evt)
  );

  load_event_sync u_rd_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (rd_load),
    .pulse_o (rd_evt)
  );

  // state, bank/offset bookkeeping and registered command fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b1;
      rd_src_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      rr_last_q  <= GNT_RD;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      clr_q      <= 1'b0;
      wr_off_q   <= '0;
      rd_off_q   <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_src_q   <= rd_src_d;
      frame_ok_q <= frame_ok_d;
      rr_last_q  <= rr_last_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      clr_q      <= clr_d;
      wr_off_q   <= wr_off_d;
      rd_off_q   <= rd_off_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
    end
  end

  // load consumption, arbitration and burst sequencing
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_src_d   = rd_src_q;
    frame_ok_d = frame_ok_q;
    rr_last_d  = rr_last_q;
    wr_pend_d  = wr_pend_q | wr_evt;
    rd_pend_d  = rd_pend_q | rd_evt;
    clr_d      = 1'b0;
    wr_off_d   = wr_off_q;
    rd_off_d   = rd_off_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    wr_el      = 1'b0;
    rd_el      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (calib_done) state_d = ARB;
      end
      ARB: begin
        // write load first so a same-cycle read load
        // picks up the frame that just completed
        if (wr_pend_q) begin
          wr_bank_d  = ~wr_bank_q;
          rd_src_d   = wr_bank_q;
          frame_ok_d = 1'b1;
          wr_off_d   = '0;
          wr_pend_d  = wr_evt;
        end
        if (rd_pend_q) begin
          rd_bank_d = rd_src_d;
          rd_off_d  = '0;
          clr_d     = 1'b1;
          rd_pend_d = rd_evt;
        end
        wr_el = wrfifo_level >= WR_MIN;
        rd_el = frame_ok_d && (rdfifo_level < RD_MAX);
        if (!calib_done) begin
          state_d = IDLE;
        end else if (wr_el && (!rd_el || rr_last_q == GNT_RD)) begin
          state_d = WR_CMD;
          addr_d  = base(wr_bank_d) + wr_off_d;
        end else if (rd_el) begin
          state_d = RD_CMD;
          addr_d  = base(rd_bank_d) + rd_off_d;
        end
      end
      WR_CMD: begin
        if (app_cmd_rdy) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (app_wdf_rdy) begin
          if (beat_q == LAST_BEAT) begin
            beat_d    = '0;
            state_d   = ARB;
            rr_last_d = GNT_WR;
            wr_off_d  = next_off(wr_off_q);
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      RD_CMD: begin
        if (app_cmd_rdy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (app_rd_data_valid) begin
          if (beat_q == LAST_BEAT) begin
            beat_d    = '0;
            state_d   = ARB;
            rr_last_d = GNT_RD;
            rd_off_d  = next_off(rd_off_q);
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign app_cmd_en = (state_q == WR_CMD) || (state_q == RD_CMD);
  assign app_cmd    = (state_q == RD_CMD) ? CMD_RD : CMD_WR;
  assign app_addr   = addr_q;
  assign app_burst_number = app_cmd_en ? BNUM : 6'd0;
  assign app_wdf_wren = (state_q == WR_DATA) && app_wdf_rdy;
  assign app_wdf_end  = app_wdf_wren;
  assign wrfifo_rden  = app_wdf_wren;
  assign rdfifo_wren  = (state_q == RD_WAIT) && app_rd_data_valid;
  assign rdfifo_clr   = clr_q;
  assign busy = !((state_q == IDLE) || (state_q == ARB));

endmodule

// File: tb/tb_ddr_frame_scheduler.sv
// Directed bench for ddr_frame_scheduler: arbitration,
// ping-pong addressing, load events and reset behaviour.
module tb_ddr_frame_scheduler;
  import ddr_sched_pkg::*;

  // short frame so the offset wrap is reached in 4 bursts
  localparam int FMAX = 7680;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        calib_done = 1'b0;
  logic        wr_load = 1'b0;
  logic        rd_load = 1'b0;
  logic [9:0]  wrfifo_level = '0;
  logic [9:0]  rdfifo_level = '0;
  logic        app_cmd_rdy = 1'b1;
  logic        app_wdf_rdy = 1'b1;
  logic        app_rd_data_valid = 1'b0;
  logic        wrfifo_rden, rdfifo_wren, rdfifo_clr;
  logic [2:0]  app_cmd;
  logic        app_cmd_en;
  logic [28:0] app_addr;
  logic [5:0]  app_burst_number;
  logic        app_wdf_wren, app_wdf_end, busy;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int wren_cnt = 0;
  int rden_cnt = 0;
  int rdwr_cnt = 0;
  int clr_cnt = 0;
  int mis_cnt = 0;
  int rd_owed = 0;
  int e0;
  bit wdf_tog = 1'b0;
  bit rdv_en = 1'b1;
  logic [2:0]  log_cmd[$];
  logic [28:0] log_addr[$];
  logic [5:0]  last_bn = '0;

  ddr_frame_scheduler #(.FRAME_MAX(FMAX)) dut (
    .clk               (clk),
    .reset             (reset),
    .calib_done        (calib_done),
    .wr_load           (wr_load),
    .rd_load           (rd_load),
    .wrfifo_level      (wrfifo_level),
    .rdfifo_level      (rdfifo_level),
    .wrfifo_rden       (wrfifo_rden),
    .rdfifo_wren       (rdfifo_wren),
    .rdfifo_clr        (rdfifo_clr),
    .app_cmd           (app_cmd),
    .app_cmd_en        (app_cmd_en),
    .app_addr          (app_addr),
    .app_burst_number  (app_burst_number),
    .app_cmd_rdy       (app_cmd_rdy),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_rd_data_valid (app_rd_data_valid),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $fatal(1, "FAIL watchdog expired");
  end

  // controller model: write-data ready and read-data beats
  always @(posedge clk) begin
    #1;
    app_wdf_rdy = wdf_tog ? ~app_wdf_rdy : 1'b1;
    if (rdv_en && rd_owed > 0) begin
      app_rd_data_valid = 1'b1;
      rd_owed--;
    end else begin
      app_rd_data_valid = 1'b0;
    end
  end

  // observe outputs mid-cycle
  always @(negedge clk) begin
    if (app_cmd_en) en_cnt++;
    if (app_cmd_en && app_cmd_rdy) begin
      log_cmd.push_back(app_cmd);
      log_addr.push_back(app_addr);
      last_bn = app_burst_number;
      if (app_cmd == 3'b001) rd_owed += 240;
    end
    if (app_wdf_wren) wren_cnt++;
    if (wrfifo_rden) rden_cnt++;
    if (wrfifo_rden !== app_wdf_wren) mis_cnt++;
    if (app_wdf_end !== app_wdf_wren) mis_cnt++;
    if (rdfifo_wren) rdwr_cnt++;
    if (rdfifo_clr) clr_cnt++;
  end

  function automatic logic [63:0] outs();
    return 64'({wrfifo_rden, rdfifo_wren, rdfifo_clr,
                app_cmd, app_cmd_en, app_addr,
                app_burst_number, app_wdf_wren,
                app_wdf_end, busy});
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_cmds(input int n, input string tag);
    int k;
    k = 0;
    while (log_cmd.size() < n && k < 3000) begin
      cyc(1);
      k++;
    end
    chk({tag, " cmd wait"},
        64'(log_cmd.size() >= n), 64'd1);
  endtask

  task automatic wait_free(input string tag);
    int k;
    k = 0;
    while (busy && k < 3000) begin
      cyc(1);
      k++;
    end
    chk({tag, " burst end wait"}, 64'(busy), 64'd0);
  endtask

  task automatic pulse_loads(input bit w, input bit r);
    wr_load = w;
    rd_load = r;
    cyc(4);
    wr_load = 1'b0;
    rd_load = 1'b0;
    cyc(4);
  endtask

  initial begin
    cyc(2);
    chk("reset outputs", outs(), 64'd0);

    // 1: no traffic before calibration, then one write
    wrfifo_level = 10'd300;
    reset = 1'b0;
    cyc(100);
    chk("uncal cmd_en count", 64'(en_cnt), 64'd0);
    chk("uncal busy", 64'(busy), 64'd0);
    calib_done = 1'b1;
    wait_cmds(1, "t1");
    wrfifo_level = 10'd0;
    chk("t1 cmd", 64'(log_cmd[0]), 64'd0);
    chk("t1 addr", 64'(log_addr[0]), 64'd0);
    chk("t1 burst_number", 64'(last_bn), 64'd47);
    wait_free("t1");
    cyc(5);
    chk("t1 rden beats", 64'(rden_cnt), 64'd240);
    chk("t1 wren beats", 64'(wren_cnt), 64'd240);

    // 2: write data ready toggling every cycle
    rden_cnt = 0;
    wren_cnt = 0;
    wdf_tog = 1'b1;
    wrfifo_level = 10'd300;
    wait_cmds(2, "t2");
    wrfifo_level = 10'd0;
    chk("t2 addr", 64'(log_addr[1]), 64'd1920);
    wait_free("t2");
    cyc(5);
    chk("t2 wren beats", 64'(wren_cnt), 64'd240);
    chk("t2 rden beats", 64'(rden_cnt), 64'd240);
    chk("t2 rden/wren/end equal", 64'(mis_cnt), 64'd0);
    wdf_tog = 1'b0;

    // 3: fresh reset, first frame, both sides eligible
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    rdfifo_level = 10'd600;
    cyc(3);
    pulse_loads(1'b1, 1'b0);
    cyc(4);
    chk("t3 no clr on wr_load", 64'(clr_cnt), 64'd0);
    wrfifo_level = 10'd300;
    rdfifo_level = 10'd0;
    wait_cmds(7, "t3");
    wrfifo_level = 10'd0;
    rdfifo_level = 10'd600;
    wait_free("t3");
    chk("t3 grant order W R W R W",
        64'({log_cmd[2], log_cmd[3], log_cmd[4],
             log_cmd[5], log_cmd[6]}),
        64'({3'd0, 3'd1, 3'd0, 3'd1, 3'd0}));
    chk("t3 wr addr 0", 64'(log_addr[2]), 64'h400000);
    chk("t3 wr addr 1", 64'(log_addr[4]), 64'h400780);
    chk("t3 wr addr 2", 64'(log_addr[6]), 64'h400f00);
    chk("t3 rd addr 0", 64'(log_addr[3]), 64'h400000);
    chk("t3 rd addr 1", 64'(log_addr[5]), 64'h400780);
    chk("t3 read beats", 64'(rdwr_cnt), 64'd480);

    // 4: offset wrap at frame end, then bank swaps
    wrfifo_level = 10'd300;
    wait_cmds(9, "t4 wrap");
    wrfifo_level = 10'd0;
    wait_free("t4 wrap");
    chk("t4 last addr", 64'(log_addr[7]), 64'h401680);
    chk("t4 wrapped addr", 64'(log_addr[8]), 64'h400000);
    pulse_loads(1'b1, 1'b0);
    cyc(4);
    wrfifo_level = 10'd300;
    wait_cmds(10, "t4 swap");
    wrfifo_level = 10'd0;
    wait_free("t4 swap");
    chk("t4 wr after swap", 64'(log_addr[9]), 64'd0);
    pulse_loads(1'b0, 1'b1);
    cyc(4);
    chk("t4 clr pulse", 64'(clr_cnt), 64'd1);
    rdfifo_level = 10'd0;
    wait_cmds(11, "t4 rd");
    rdfifo_level = 10'd600;
    wait_free("t4 rd");
    chk("t4 rd cmd", 64'(log_cmd[10]), 64'd1);
    chk("t4 rd addr", 64'(log_addr[10]), 64'h400000);

    // 5: both loads arrive during a write burst
    wrfifo_level = 10'd300;
    wait_cmds(12, "t5");
    wrfifo_level = 10'd0;
    chk("t5 wr addr", 64'(log_addr[11]), 64'h780);
    pulse_loads(1'b1, 1'b1);
    chk("t5 still bursting", 64'(busy), 64'd1);
    chk("t5 no clr mid-burst", 64'(clr_cnt), 64'd1);
    wait_free("t5");
    cyc(4);
    chk("t5 single clr", 64'(clr_cnt), 64'd2);
    rdfifo_level = 10'd0;
    wait_cmds(13, "t5 rd");
    rdfifo_level = 10'd600;
    chk("t5 rd addr", 64'(log_addr[12]), 64'd0);
    wrfifo_level = 10'd300;
    wait_cmds(14, "t5 wr");
    wrfifo_level = 10'd0;
    wait_free("t5 wr");
    chk("t5 wr new bank", 64'(log_addr[13]), 64'h400000);
    chk("t5 clr count", 64'(clr_cnt), 64'd2);

    // 6: reset while waiting for read data
    rdv_en = 1'b0;
    rdfifo_level = 10'd0;
    wait_cmds(15, "t6");
    rdfifo_level = 10'd600;
    cyc(5);
    chk("t6 in burst", 64'(busy), 64'd1);
    chk("t6 addr before reset", 64'(app_addr), 64'h780);
    reset = 1'b1;
    #1;
    chk("t6 outputs at reset", outs(), 64'd0);
    cyc(2);
    reset = 1'b0;
    rd_owed = 0;
    rdv_en = 1'b1;
    rdfifo_level = 10'd0;
    e0 = en_cnt;
    cyc(50);
    chk("t6 no read w/o frame", 64'(en_cnt - e0), 64'd0);
    chk("t6 idle busy", 64'(busy), 64'd0);
    pulse_loads(1'b1, 1'b0);
    wait_cmds(16, "t6 rd");
    rdfifo_level = 10'd600;
    wait_free("t6 rd");
    chk("t6 rd cmd", 64'(log_cmd[15]), 64'd1);
    chk("t6 rd addr", 64'(log_addr[15]), 64'h400000);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
